// File: rtl/mul_operand_sequencer_pkg.sv
// Shared types and defaults for the multiplier operand sequencer.
package mul_seq_pkg;

    localparam int MUL_WIDTH  = 6;
    localparam int MUL_CYCLES = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mul_state_e;

    typedef struct packed {
        logic [MUL_WIDTH-1:0] a;
        logic [MUL_WIDTH-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/mul_operand_sequencer_fifo.sv
// Circular operand FIFO (power-of-2 depth, wrap-around pointers, occupancy count).
// Used by mul_operand_sequencer only when MUL_SEQ_FIFO_EN is defined.
module operand_fifo
    import mul_seq_pkg::*;
#(
    parameter int WIDTH      = MUL_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_a,
    input  logic [WIDTH-1:0] push_b,
    input  logic             pop,
    output logic [WIDTH-1:0] head_a,
    output logic [WIDTH-1:0] head_b,
    output logic             full,
    output logic             empty
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [2*WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [PW:0]        count_r;
    logic               do_push_s;
    logic               do_pop_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == {(PW+1){1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head_a    = mem_r[rd_ptr_r][2*WIDTH-1:WIDTH];
    assign head_b    = mem_r[rd_ptr_r][WIDTH-1:0];

    // Storage, pointers and occupancy; power-of-2 depth lets pointers wrap by overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {(2*WIDTH){1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= {push_a, push_b};
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mul_operand_sequencer.sv
// Operand sequencer wrapping the shift-add multiplier: buffers pairs, pulses load, captures product.
// Define MUL_SEQ_FIFO_EN for a FIFO_DEPTH-entry operand FIFO instead of a single holding register.
module mul_operand_sequencer #(
    parameter int WIDTH      = mul_seq_pkg::MUL_WIDTH,
    parameter int MUL_CYCLES = mul_seq_pkg::MUL_CYCLES
`ifdef MUL_SEQ_FIFO_EN
    ,
    parameter int FIFO_DEPTH = 4
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mul_load,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy
);

    import mul_seq_pkg::*;

    localparam int CW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    mul_state_e         state_r;
    logic [CW-1:0]      cnt_r;
    logic               mul_load_r;
    logic [WIDTH-1:0]   mul_a_r;
    logic [WIDTH-1:0]   mul_b_r;
    logic               out_valid_r;
    logic [2*WIDTH-1:0] out_product_r;

    logic               push_s;
    logic               pop_s;
    logic               buf_full_s;
    logic               buf_empty_s;
    logic [WIDTH-1:0]   buf_a_s;
    logic [WIDTH-1:0]   buf_b_s;

    // Acceptance depends only on registered occupancy, so a same-cycle pop never frees a slot early.
    assign in_ready = !buf_full_s;
    assign push_s   = in_valid && !buf_full_s;
    assign pop_s    = (state_r == IDLE) && !buf_empty_s;

`ifdef MUL_SEQ_FIFO_EN
    operand_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push_s),
        .push_a (in_a),
        .push_b (in_b),
        .pop    (pop_s),
        .head_a (buf_a_s),
        .head_b (buf_b_s),
        .full   (buf_full_s),
        .empty  (buf_empty_s)
    );
`else
    logic             hold_full_r;
    logic [WIDTH-1:0] hold_a_r;
    logic [WIDTH-1:0] hold_b_r;

    assign buf_full_s  = hold_full_r;
    assign buf_empty_s = !hold_full_r;
    assign buf_a_s     = hold_a_r;
    assign buf_b_s     = hold_b_r;

    // Single-entry lookahead register; push only when empty and pop only when full, so never both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full_r <= 1'b0;
            hold_a_r    <= {WIDTH{1'b0}};
            hold_b_r    <= {WIDTH{1'b0}};
        end else if (push_s) begin
            hold_full_r <= 1'b1;
            hold_a_r    <= in_a;
            hold_b_r    <= in_b;
        end else if (pop_s) begin
            hold_full_r <= 1'b0;
        end else begin
            hold_full_r <= hold_full_r;
        end
    end
`endif

    // Sequencing FSM: one multiplication in flight, fixed wait, then hold the result until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            cnt_r         <= {CW{1'b0}};
            mul_load_r    <= 1'b0;
            mul_a_r       <= {WIDTH{1'b0}};
            mul_b_r       <= {WIDTH{1'b0}};
            out_valid_r   <= 1'b0;
            out_product_r <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        mul_a_r    <= buf_a_s;
                        mul_b_r    <= buf_b_s;
                        mul_load_r <= 1'b1;
                        state_r    <= LOAD;
                    end
                end
                LOAD: begin
                    mul_load_r <= 1'b0;
                    cnt_r      <= {CW{1'b0}};
                    state_r    <= WAIT;
                end
                WAIT: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        out_product_r <= mul_product;
                        out_valid_r   <= 1'b1;
                        state_r       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    mul_load_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign mul_load    = mul_load_r;
    assign mul_a       = mul_a_r;
    assign mul_b       = mul_b_r;
    assign out_valid   = out_valid_r;
    assign out_product = out_product_r;
    assign busy        = (state_r != IDLE) || !buf_empty_s;

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Self-checking bench for mul_operand_sequencer with a behavioural multiplier and result scoreboard.
module tb_mul_operand_sequencer;
    import mul_seq_pkg::*;

    localparam int W  = MUL_WIDTH;
    localparam int MC = MUL_CYCLES;
`ifdef MUL_SEQ_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           mul_load;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [2*W-1:0] mul_product;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_product;
    logic           busy;

    always #5 clk = ~clk;

    mul_operand_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_load    (mul_load),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .busy        (busy)
    );

    function automatic logic [2*W-1:0] mulw(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] x;
        logic [2*W-1:0] y;
        x = {{W{1'b0}}, a};
        y = {{W{1'b0}}, b};
        return x * y;
    endfunction

    // Behavioural multiplier: product is only valid MC-1 edges after the load-sample edge.
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    int           m_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_a <= '0; m_b <= '0; m_cnt <= MC;
        end else if (mul_load) begin
            m_a <= mul_a; m_b <= mul_b; m_cnt <= 0;
        end else if (m_cnt < MC) begin
            m_cnt <= m_cnt + 1;
        end
    end
    assign mul_product = (m_cnt >= MC - 1) ? mulw(m_a, m_b) : ~mulw(m_a, m_b);

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int loads = 0;
    logic [2*W-1:0] exp_q[$];
    int             out_times[$];
    logic [2*W-1:0] held_prod;
    bit             held_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: sampled mid-cycle, transfers take effect at the following edge.
    always @(negedge clk) begin
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (mul_load) loads++;
            if (in_valid && in_ready) exp_q.push_back(mulw(in_a, in_b));
            if (out_valid) begin
                if (held_v) check("hold_stable", out_product, held_prod);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_unexpected: got product %0d, expected no result", out_product);
                    end else begin
                        check("sb_product", out_product, exp_q.pop_front());
                    end
                    out_times.push_back(cyc);
                    held_v = 1'b0;
                end else begin
                    held_prod = out_product;
                    held_v    = 1'b1;
                end
            end
        end
    end

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input int budget, output bit ok);
        in_a = a; in_b = b; in_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget, output int lat);
        lat = 0;
        while (!out_valid && lat < budget) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i = 0;
        while ((busy || exp_q.size() != 0) && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        check(name, exp_q.size(), 0);
        check({name, "_busy"}, busy, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_mul_load"}, mul_load, 0);
        check({tag, "_mul_a"}, mul_a, 0);
        check({tag, "_mul_b"}, mul_b, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_product"}, out_product, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    typedef struct {
        operand_pair_t  pair;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int lat;
        int l0;
        int t0;
        int acc;
        int ti;

        vecs[0] = '{pair: '{a: 6'd6,  b: 6'd7},  exp: 12'd42};
        vecs[1] = '{pair: '{a: 6'd63, b: 6'd63}, exp: 12'd3969};
        vecs[2] = '{pair: '{a: 6'd0,  b: 6'd45}, exp: 12'd0};
        vecs[3] = '{pair: '{a: 6'd1,  b: 6'd63}, exp: 12'd63};
        vecs[4] = '{pair: '{a: 6'd37, b: 6'd22}, exp: 12'd814};

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        // Single transactions: latency, product, one load pulse, back to idle.
        for (int v = 0; v < 5; v++) begin
            l0 = loads;
            push(vecs[v].pair.a, vecs[v].pair.b, 4, ok);
            check("vec_accept", ok, 1);
            wait_out(20, lat);
            check("vec_latency", lat, MC + 2);
            check("vec_product", out_product, vecs[v].exp);
            @(posedge clk); #1;
            check("vec_one_load", loads - l0, 1);
            check("vec_out_valid_low", out_valid, 0);
            check("vec_idle", busy, 0);
        end

        // Back-to-back pairs with downstream stalled: first result held, then in-order drain.
        out_ready = 1'b0;
        ti = out_times.size();
        fork
            begin
                push(6'd3, 6'd5, 4, ok);
                push(6'd10, 6'd2, 40, ok);
                push(6'd7, 6'd9, 60, ok);
                check("b2b_third_accept", ok, 1);
            end
            begin
                repeat (15) begin @(posedge clk); #1; end
                check("stall_valid", out_valid, 1);
                check("stall_product", out_product, 15);
                repeat (5) begin @(posedge clk); #1; end
                check("stall_product_later", out_product, 15);
                out_ready = 1'b1;
            end
        join
        wait_drain("b2b_drain", 100);
        check("b2b_count", out_times.size() - ti, 3);

        // Capacity: CAP buffered plus one in flight, then refusal; done twice to exercise wrap.
        for (int rep = 0; rep < 2; rep++) begin
            out_ready = 1'b0;
            acc = 0;
            ti  = out_times.size();
            for (int i = 0; i < CAP + 2; i++) begin
                push(6'(i + 1 + rep * 8), 6'(i + 2), 4, ok);
                if (ok) acc++;
            end
            check("cap_accepted", acc, CAP + 1);
            check("cap_in_ready_full", in_ready, 0);
            out_ready = 1'b1;
            wait_drain("cap_drain", 200);
            check("cap_count", out_times.size() - ti, CAP + 1);
        end

        // Reset during WAIT with a pair buffered behind the one in flight.
        out_ready = 1'b0;
        push(6'd9, 6'd9, 4, ok);
        t0 = cyc;
        push(6'd2, 6'd3, 4, ok);
        while (cyc < t0 + 5) begin @(posedge clk); #1; end
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_reset_values("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        push(6'd4, 6'd4, 4, ok);
        wait_out(20, lat);
        check("post_reset_latency", lat, MC + 2);
        check("post_reset_product", out_product, 16);
        wait_drain("post_reset_drain", 50);

        // Continuous traffic with out_ready held high: one result every MC+3 clocks.
        ti = out_times.size();
        for (int i = 0; i < 4; i++) begin
            push(6'(5 + i), 6'(11 + 3 * i), 30, ok);
        end
        wait_drain("stream_drain", 100);
        check("stream_count", out_times.size() - ti, 4);
        for (int k = 1; k < 4; k++) begin
            if (out_times.size() > ti + k) begin
                check("stream_interval", out_times[ti + k] - out_times[ti + k - 1], MC + 3);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
